// File: rtl/avl_ctrl_regs_slave.sv
// Avalon-MM control/status register slave for the NN core.
// Holds the start/ack/done handshake FSM, the image and result base
// addresses, sticky DONE/ERR flags and a level interrupt.
// Optional build macro: CTRL_REGS_FRAME_CNT_EN adds a 32-bit frame counter at word 0x4.
module avl_ctrl_regs_slave #(
  parameter int unsigned ADDR_W      = 20,
  parameter logic [31:0] ID_VALUE    = 32'hDE57_0001,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  output logic              core_start,
  input  logic              core_ack,
  input  logic              core_done,
  output logic [31:0]       img_base,
  output logic [31:0]       res_base,
  output logic              soft_rst,
  output logic              irq
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StRun} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_q, rdv_q, irq_q, irq_en_q, done_q, err_q;
  logic             core_start_q, soft_rst_q;
  logic [31:0]      rdata_q, img_base_q, res_base_q, frame_cnt, rd_mux;
  logic             done_d, err_d, start_issue, done_set, err_set, frame_inc;

  function automatic logic [31:0] be_merge(input logic [31:0] cur, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? wd[8*b +: 8] : cur[8*b +: 8];
    return res;
  endfunction

  // Bus decode; the stall covers reset and the first cycle after it.
  logic [3:0] addr;
  logic       accept, wr_en, rd_en, ctrl_wr, status_wr, start_wr, srst_wr;
  assign addr            = avs_address[3:0];
  assign avs_waitrequest = reset | wait_q;
  assign accept          = ~avs_waitrequest;
  assign wr_en           = accept & avs_write;
  assign rd_en           = accept & avs_read & ~avs_write;  // write wins, read dropped
  assign ctrl_wr         = wr_en & (addr == 4'h0) & avs_byteenable[0];
  assign status_wr       = wr_en & (addr == 4'h1) & avs_byteenable[0];
  assign start_wr        = ctrl_wr & avs_writedata[0];
  assign srst_wr         = ctrl_wr & avs_writedata[2];

  // Handshake FSM next state, timeout counter and event strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_issue = 1'b0;
    err_set     = 1'b0;
    done_set    = 1'b0;
    frame_inc   = 1'b0;
    if (srst_wr) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_wr) begin
            start_issue = 1'b1;
            state_d     = StArmed;
            cnt_d       = '0;
          end
        end
        StArmed: begin
          if (start_wr) err_set = 1'b1;
          if (core_ack) begin
            state_d = StRun;
          end else if (cnt_q == CNT_LAST) begin
            state_d = StIdle;
            err_set = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StRun: begin
          if (start_wr) err_set = 1'b1;
          if (core_done) begin
            done_set  = 1'b1;
            frame_inc = 1'b1;
            state_d   = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a W1C wins.
  always_comb begin
    done_d = done_set | (done_q & ~(status_wr & avs_writedata[1]));
    err_d  = err_set  | (err_q  & ~(status_wr & avs_writedata[2]));
  end

  // Read data mux over the decoded register map.
  always_comb begin
    rd_mux = '0;
    case (addr)
      4'h0:    rd_mux = {30'b0, irq_en_q, 1'b0};
      4'h1:    rd_mux = {29'b0, err_q, done_q, (state_q != StIdle)};
      4'h2:    rd_mux = img_base_q;
      4'h3:    rd_mux = res_base_q;
      4'h4:    rd_mux = frame_cnt;
      4'h5:    rd_mux = ID_VALUE;
      default: rd_mux = '0;
    endcase
  end

  // Bus response, control registers and FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q       <= 1'b1;
      rdv_q        <= 1'b0;
      rdata_q      <= '0;
      state_q      <= StIdle;
      cnt_q        <= '0;
      core_start_q <= 1'b0;
      soft_rst_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      irq_q        <= 1'b0;
      irq_en_q     <= 1'b0;
      img_base_q   <= '0;
      res_base_q   <= '0;
    end else begin
      wait_q       <= 1'b0;
      rdv_q        <= rd_en;
      rdata_q      <= rd_en ? rd_mux : '0;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_start_q <= start_issue;
      soft_rst_q   <= srst_wr;
      done_q       <= done_d;
      err_q        <= err_d;
      irq_q        <= done_q & irq_en_q;
      if (ctrl_wr) irq_en_q <= avs_writedata[1];
      if (wr_en && addr == 4'h2) img_base_q <= be_merge(img_base_q, avs_writedata, avs_byteenable);
      if (wr_en && addr == 4'h3) res_base_q <= be_merge(res_base_q, avs_writedata, avs_byteenable);
    end
  end

`ifdef CTRL_REGS_FRAME_CNT_EN
  logic [31:0] frame_cnt_q;
  // Completed-frame counter; wraps naturally, cleared by soft reset.
  always_ff @(posedge clk) begin
    if (reset || srst_wr) frame_cnt_q <= '0;
    else if (frame_inc)   frame_cnt_q <= frame_cnt_q + 32'd1;
  end
  assign frame_cnt = frame_cnt_q;
  logic unused_bits;
  assign unused_bits = ^avs_address[ADDR_W-1:4];
`else
  assign frame_cnt = '0;
  logic unused_bits;
  assign unused_bits = ^{avs_address[ADDR_W-1:4], frame_inc};
`endif

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rdv_q;
  assign core_start        = core_start_q;
  assign soft_rst          = soft_rst_q;
  assign irq               = irq_q;
  assign img_base          = img_base_q;
  assign res_base          = res_base_q;

endmodule

// File: tb/tb_avl_ctrl_regs_slave.sv
// Bench for avl_ctrl_regs_slave: register-map vector table plus hand-written
// handshake sequences; read responses are checked against a queue of expected data.
module tb_avl_ctrl_regs_slave;

  localparam int unsigned ADDR_W = 20;
  localparam logic [31:0] ID     = 32'hDE57_0001;
  localparam int unsigned T      = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read, avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid, avs_waitrequest;
  logic              core_start, core_ack, core_done;
  logic [31:0]       img_base, res_base;
  logic              soft_rst, irq;

  avl_ctrl_regs_slave #(.ADDR_W(ADDR_W), .ID_VALUE(ID), .ACK_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest(avs_waitrequest), .core_start(core_start), .core_ack(core_ack),
    .core_done(core_done), .img_base(img_base), .res_base(res_base), .soft_rst(soft_rst),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int start_pulses = 0;
  int srst_pulses = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard and pulse counters, sampled away from the rising edge.
  always @(negedge clk) begin
    if (core_start) start_pulses++;
    if (soft_rst) srst_pulses++;
    if (avs_readdatavalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_readdatavalid: got data %h expected no response", avs_readdata);
      end else begin
        check("readdata", avs_readdata, exp_q.pop_front());
      end
    end else begin
      check("readdata_zero_when_invalid", avs_readdata, 32'h0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_address = ADDR_W'(a);
    avs_writedata = d;
    avs_byteenable = be;
    avs_write = 1'b1;
    @(posedge clk);
    #1;
    avs_write = 1'b0;
    avs_byteenable = 4'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp);
    avs_address = ADDR_W'(a);
    avs_read = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    avs_read = 1'b0;
  endtask

  task automatic pulse_ack();
    core_ack = 1'b1;
    @(posedge clk);
    #1;
    core_ack = 1'b0;
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    @(posedge clk);
    #1;
    core_done = 1'b0;
  endtask

  typedef struct packed {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[21];
  int   sp, rp;

  initial begin
    vecs[0]  = '{1'b0, 4'h5, 32'h0,         4'h0, ID};
    vecs[1]  = '{1'b0, 4'h7, 32'h0,         4'h0, 32'h0};
    vecs[2]  = '{1'b1, 4'h2, 32'hAABBCCDD,  4'h5, 32'h0};
    vecs[3]  = '{1'b0, 4'h2, 32'h0,         4'h0, 32'h00BB00DD};
    vecs[4]  = '{1'b1, 4'h3, 32'h12345678,  4'hF, 32'h0};
    vecs[5]  = '{1'b1, 4'h3, 32'hFFFFFFFF,  4'h0, 32'h0};
    vecs[6]  = '{1'b0, 4'h3, 32'h0,         4'h0, 32'h12345678};
    vecs[7]  = '{1'b1, 4'h3, 32'hFFFFFFFF,  4'h8, 32'h0};
    vecs[8]  = '{1'b0, 4'h3, 32'h0,         4'h0, 32'hFF345678};
    vecs[9]  = '{1'b1, 4'h7, 32'hDEADBEEF,  4'hF, 32'h0};
    vecs[10] = '{1'b0, 4'h7, 32'h0,         4'h0, 32'h0};
    vecs[11] = '{1'b1, 4'h5, 32'h0,         4'hF, 32'h0};
    vecs[12] = '{1'b0, 4'h5, 32'h0,         4'h0, ID};
    vecs[13] = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0};
    vecs[14] = '{1'b1, 4'h0, 32'hFFFFFFFA,  4'hF, 32'h0};
    vecs[15] = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h2};
    vecs[16] = '{1'b1, 4'h0, 32'h0,         4'hF, 32'h0};
    vecs[17] = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0};
    vecs[18] = '{1'b0, 4'h1, 32'h0,         4'h0, 32'h0};
    vecs[19] = '{1'b1, 4'h1, 32'hFFFFFFFF,  4'hF, 32'h0};
    vecs[20] = '{1'b0, 4'h1, 32'h0,         4'h0, 32'h0};

    reset = 1'b1;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    avs_byteenable = '0;
    core_ack = 1'b0;
    core_done = 1'b0;

    // Reset values and the post-reset stall.
    idle(3);
    check("rst_waitrequest", {31'b0, avs_waitrequest}, 32'h1);
    check("rst_readdatavalid", {31'b0, avs_readdatavalid}, 32'h0);
    check("rst_core_start", {31'b0, core_start}, 32'h0);
    check("rst_soft_rst", {31'b0, soft_rst}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_img_base", img_base, 32'h0);
    check("rst_res_base", res_base, 32'h0);
    reset = 1'b0;
    #2;
    check("waitrequest_first_cycle", {31'b0, avs_waitrequest}, 32'h1);
    idle(1);
    check("waitrequest_released", {31'b0, avs_waitrequest}, 32'h0);

    // Register map vectors.
    for (int i = 0; i < 21; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data, vecs[i].be);
      else bus_read(vecs[i].addr, vecs[i].exp);
    end
    check("img_base_port", img_base, 32'h00BB00DD);
    check("res_base_port", res_base, 32'hFF345678);

    // Read and write together: write lands, read produces no response.
    avs_read = 1'b1;
    bus_write(4'h2, 32'h11223344, 4'hF);
    avs_read = 1'b0;
    bus_read(4'h2, 32'h11223344);

    // Full frame: start with IRQ_EN, ack after 2 cycles, done after 10 more.
    sp = start_pulses;
    bus_write(4'h0, 32'h3, 4'h1);
    bus_read(4'h1, 32'h1);
    pulse_ack();
    for (int i = 0; i < 9; i++) bus_read(4'h1, 32'h1);
    pulse_done();
    check("irq_lags_done", {31'b0, irq}, 32'h0);
    idle(1);
    check("irq_after_done", {31'b0, irq}, 32'h1);
    bus_read(4'h1, 32'h2);
    check("one_start_pulse", 32'(start_pulses - sp), 32'h1);

    // Clear DONE; core_done ignored in IDLE and ARMED.
    bus_write(4'h1, 32'h2, 4'h1);
    bus_read(4'h1, 32'h0);
    check("irq_dropped", {31'b0, irq}, 32'h0);
    pulse_done();
    bus_read(4'h1, 32'h0);
    bus_write(4'h0, 32'h3, 4'h1);
    pulse_done();
    bus_read(4'h1, 32'h1);
    pulse_ack();

    // W1C of DONE coinciding with core_done: set wins.
    core_done = 1'b1;
    bus_write(4'h1, 32'h2, 4'h1);
    core_done = 1'b0;
    bus_read(4'h1, 32'h2);
    bus_write(4'h1, 32'h2, 4'h1);
    bus_read(4'h1, 32'h0);
    check("irq_after_w1c", {31'b0, irq}, 32'h0);

    // Ack timeout: busy through the last armed cycle, then ERR and IDLE.
    bus_write(4'h0, 32'h3, 4'h1);
    idle(T - 2);
    bus_read(4'h1, 32'h1);
    bus_read(4'h1, 32'h1);
    bus_read(4'h1, 32'h4);
    bus_write(4'h1, 32'h4, 4'h1);
    bus_read(4'h1, 32'h0);

    // START while running: ERR, no extra pulse, state kept.
    sp = start_pulses;
    bus_write(4'h0, 32'h3, 4'h1);
    pulse_ack();
    bus_write(4'h0, 32'h3, 4'h1);
    bus_read(4'h1, 32'h5);
    check("no_start_in_run", 32'(start_pulses - sp), 32'h1);
    pulse_done();
    bus_read(4'h1, 32'h6);
    bus_write(4'h1, 32'h6, 4'h1);
    bus_read(4'h1, 32'h0);

    // Soft reset: back to IDLE with ERR kept; beats a coincident START.
    sp = start_pulses;
    rp = srst_pulses;
    bus_write(4'h0, 32'h3, 4'h1);
    pulse_ack();
    bus_write(4'h0, 32'h3, 4'h1);
    bus_write(4'h0, 32'h6, 4'h1);
    bus_read(4'h1, 32'h4);
    bus_write(4'h0, 32'h7, 4'h1);
    bus_read(4'h1, 32'h4);
    check("soft_rst_start_pulses", 32'(start_pulses - sp), 32'h1);
    check("soft_rst_pulses", 32'(srst_pulses - rp), 32'h2);
    bus_write(4'h1, 32'h4, 4'h1);

`ifdef CTRL_REGS_FRAME_CNT_EN
    bus_read(4'h4, 32'h0);
    force dut.frame_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.frame_cnt_q;
    bus_read(4'h4, 32'hFFFFFFFF);
    bus_write(4'h0, 32'h3, 4'h1);
    pulse_ack();
    pulse_done();
    bus_read(4'h4, 32'h0);
    bus_write(4'h1, 32'h2, 4'h1);
`else
    bus_read(4'h4, 32'h0);
`endif

    // Reset in the middle of a handshake.
    bus_write(4'h0, 32'h3, 4'h1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    check("ready_after_mid_reset", {31'b0, avs_waitrequest}, 32'h0);
    bus_read(4'h1, 32'h0);
    bus_read(4'h0, 32'h0);
    bus_read(4'h2, 32'h0);

    idle(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avl_ctrl_regs_slave.md
AVL_CTRL_REGS_SLAVE -- requirements
Module: avl_ctrl_regs_slave

Interface
REQ-001 Parameter ADDR_W, 20, Avalon word-address width; only address[3:0] are decoded.
REQ-002 Parameter ID_VALUE, 32'hDE57_0001, constant returned by the ID register.
REQ-003 Parameter ACK_TIMEOUT, 1024, maximum number of cycles to wait for core_ack after a start.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port list:
- clk  in  1  single clock; all logic samples on the rising edge.
- reset  in  1  synchronous, active-high reset.
- avs_address  in  ADDR_W  word address.
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_writedata  in  32  write data.
- avs_byteenable  in  4  per-byte write enable.
- avs_readdata  out  32  read data.
- avs_readdatavalid  out  1  read response strobe.
- avs_waitrequest  out  1  slave stall.
- core_start  out  1  one-cycle start pulse to the NN core.
- core_ack  in  1  core has accepted the start.
- core_done  in  1  one-cycle frame-complete pulse from the core.
- img_base  out  32  image buffer base address.
- res_base  out  32  result buffer base address.
- soft_rst  out  1  one-cycle soft-reset pulse to the core.
- irq  out  1  level interrupt.

Function
REQ-006 Register map (word address): 0x0 CTRL, 0x1 STATUS, 0x2 IMG_BASE (RW), 0x3 RES_BASE (RW), 0x4 FRAME_CNT (RO), 0x5 ID (RO); all other addresses read 0 and ignore writes.
REQ-007 CTRL: bit0 START (write-1 pulse), bit1 IRQ_EN (RW), bit2 SOFT_RST (write-1 pulse); bits 0 and 2 always read 0.
REQ-008 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, W1C), bit2 ERR (sticky, W1C); writes to BUSY are ignored.
REQ-009 Writes to RW registers SHALL honour avs_byteenable per byte; byteenable=0 leaves the register unchanged.
REQ-010 avs_waitrequest SHALL be 1 during reset and for the first cycle after reset deasserts, and 0 otherwise; transactions are accepted only when it is 0.
REQ-011 Read latency is fixed at 1 cycle: avs_readdatavalid=1 and avs_readdata valid in the cycle after acceptance; avs_readdata=0 whenever avs_readdatavalid=0.
REQ-012 If avs_read and avs_write are both asserted, the write executes, the read is dropped, and no avs_readdatavalid is generated.
REQ-013 FSM states: IDLE, ARMED, RUN; BUSY=1 in ARMED and RUN.
- IDLE: a START write asserts core_start for 1 cycle and moves to ARMED.
- ARMED: core_ack moves to RUN; ACK_TIMEOUT cycles without core_ack set ERR and return to IDLE.
- RUN: core_done sets DONE and returns to IDLE.
REQ-014 A START write in ARMED or RUN SHALL set ERR, produce no core_start pulse and leave the state unchanged.
REQ-015 A DONE W1C write in the same cycle as core_done leaves DONE=1 (set wins); the same rule applies to ERR.
REQ-016 A SOFT_RST write pulses soft_rst for 1 cycle, forces the FSM to IDLE, clears the timeout counter and leaves DONE/ERR unchanged; if START is in the same write, SOFT_RST wins and no core_start is issued.
REQ-017 irq SHALL equal registered (DONE & IRQ_EN), i.e. it changes one cycle after its inputs.
REQ-018 The timeout counter SHALL be log2(ACK_TIMEOUT)+1 bits, load 0 on entry to ARMED, and not wrap.
REQ-019 core_done in IDLE or ARMED SHALL be ignored (no DONE set).

Reset
REQ-020 Reset SHALL force: FSM=IDLE; all registers 0; avs_readdata=0, avs_readdatavalid=0, avs_waitrequest=1; core_start=0, soft_rst=0, irq=0; img_base=res_base=0.
REQ-021 Reset asserted mid-operation SHALL abandon any pending read response and any in-progress core handshake.

Configuration
REQ-022 Macro CTRL_REGS_FRAME_CNT_EN.
- Defined: FRAME_CNT is a 32-bit counter incremented on each core_done accepted in RUN; it wraps 0xFFFFFFFF->0 and is cleared by reset and by SOFT_RST.
- Undefined: no counter logic is built and address 0x4 reads 0.

Verification
REQ-023 Read ID at 0x5 -> readdatavalid one cycle later with readdata=ID_VALUE; read 0x7 -> 0.
REQ-024 Write IMG_BASE=0xAABBCCDD with byteenable=4'b0101, starting from 0 -> readback 0x00BB00DD and img_base matches.
REQ-025 Write CTRL=0x3, then core_ack after 2 cycles, then core_done after 10 cycles -> one core_start pulse, BUSY=1 throughout, then STATUS=0x2 and irq=1 one cycle after DONE sets.
REQ-026 START with no core_ack for ACK_TIMEOUT cycles -> STATUS=0x4 and FSM back in IDLE; a second START while in RUN -> ERR=1 and no core_start pulse.
REQ-027 W1C of DONE in the same cycle as core_done -> DONE stays 1; W1C in a later cycle -> DONE=0 and irq drops.
REQ-028 With CTRL_REGS_FRAME_CNT_EN defined: preload the count to 0xFFFFFFFF via force, complete one frame -> FRAME_CNT=0; without the macro, address 0x4 reads 0.
